// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  localparam int WORD_W           = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;

  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: registered write, combinational read.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int PTR_W = fq_ptr_w(DEPTH),
  parameter int WIDTH = 2 * fetch_queue_pkg::WORD_W
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode with stall and redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH_DEFAULT,
  parameter int PTR_W  = fq_ptr_w(DEPTH),
  parameter int WORD_W = fetch_queue_pkg::WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] f_instruction,
  input  logic [WORD_W-1:0] f_address,
  output logic              f_stall,
  output logic [WORD_W-1:0] f_jump_target,
  output logic              f_jump_flg,
  input  logic              d_jump_req,
  input  logic [WORD_W-1:0] d_jump_target,
  output logic              d_valid,
  output logic [WORD_W-1:0] d_instruction,
  output logic [WORD_W-1:0] d_address,
  input  logic              d_ready,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W:0]      count_nxt;
  logic                full;
  logic                enq;
  logic                deq;
  logic [2*WORD_W-1:0] rd_data;

  assign f_jump_flg    = d_jump_req;
  assign f_jump_target = d_jump_target;

  // Stall comes only from registered occupancy, never from d_ready.
  assign full    = (count == FULL_CNT);
  assign f_stall = full && !d_jump_req;
  assign enq     = !full && !d_jump_req;
  assign d_valid = (count != '0);
  assign deq     = d_valid && d_ready;

  always_comb begin
    count_nxt = count;
    unique case ({enq, deq})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (d_jump_req) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (2 * WORD_W)
  ) u_mem (
    .clock (clock),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata ({f_instruction, f_address}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign d_instruction = rd_data[2*WORD_W-1:WORD_W];
  assign d_address     = rd_data[WORD_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a simple fetch PC model.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic [31:0] f_instruction;
  logic [31:0] f_address;
  logic        f_stall;
  logic [31:0] f_jump_target;
  logic        f_jump_flg;
  logic        d_jump_req;
  logic [31:0] d_jump_target;
  logic        d_valid;
  logic [31:0] d_instruction;
  logic [31:0] d_address;
  logic        d_ready;
  logic [2:0]  count;

  int n_checks;
  int n_fail;

  logic [31:0] pc;

  fetch_queue dut (
    .clock         (clock),
    .reset         (reset),
    .f_instruction (f_instruction),
    .f_address     (f_address),
    .f_stall       (f_stall),
    .f_jump_target (f_jump_target),
    .f_jump_flg    (f_jump_flg),
    .d_jump_req    (d_jump_req),
    .d_jump_target (d_jump_target),
    .d_valid       (d_valid),
    .d_instruction (d_instruction),
    .d_address     (d_address),
    .d_ready       (d_ready),
    .count         (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Fetch model: holds PC on stall, loads target on jump.
  always @(posedge clock or posedge reset) begin
    if (reset) pc <= 32'h0;
    else if (f_jump_flg) pc <= f_jump_target;
    else if (!f_stall) pc <= pc + 32'd4;
  end

  assign f_address     = pc;
  assign f_instruction = instr_of(pc);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int  consumed;
    int  cyc;
    logic [31:0] exp_addr;

    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    d_ready       = 1'b0;
    d_jump_req    = 1'b0;
    d_jump_target = 32'h0;

    // reset state
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(d_valid), 32'd0);
    chk("rst_stall", 32'(f_stall), 32'd0);

    // free run
    d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("run_valid", 32'(d_valid), 32'd1);
      chk("run_addr", d_address, 32'(4 * k));
      chk("run_instr", d_instruction, instr_of(32'(4 * k)));
      chk("run_stall", 32'(f_stall), 32'd0);
      chk("run_count", 32'(count), 32'd1);
    end

    // fill
    do_reset();
    d_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("fill_count", 32'(count), 32'(k));
      chk("fill_stall", 32'(f_stall), (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    chk("full_hold_cnt", 32'(count), 32'd4);
    chk("full_pc_hold", f_address, 32'h10);
    d_ready = 1'b1;
    chk("drain_first", d_address, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("drain_addr", d_address, 32'(4 * k));
      chk("drain_stall", 32'(f_stall), 32'd0);
      chk("drain_count", 32'(count), 32'd3);
    end

    // redirect with count 3
    do_reset();
    d_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rd3_count", 32'(count), 32'd3);
    d_jump_req    = 1'b1;
    d_jump_target = 32'h100;
    #1;
    chk("rd3_flg", 32'(f_jump_flg), 32'd1);
    chk("rd3_tgt", f_jump_target, 32'h100);
    @(negedge clock);
    d_jump_req = 1'b0;
    chk("rd3_flush", 32'(count), 32'd0);
    chk("rd3_novalid", 32'(d_valid), 32'd0);
    @(negedge clock);
    chk("rd3_valid", 32'(d_valid), 32'd1);
    chk("rd3_addr", d_address, 32'h100);
    chk("rd3_instr", d_instruction, instr_of(32'h100));

    // redirect while full, then back-to-back redirects
    do_reset();
    d_ready = 1'b0;
    repeat (4) @(negedge clock);
    chk("rdf_stall_pre", 32'(f_stall), 32'd1);
    d_jump_req    = 1'b1;
    d_jump_target = 32'h200;
    #1;
    chk("rdf_stall_jmp", 32'(f_stall), 32'd0);
    @(negedge clock);
    d_jump_req = 1'b0;
    chk("rdf_flush", 32'(count), 32'd0);
    d_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("rdf_valid", 32'(d_valid), 32'd1);
      chk("rdf_addr", d_address, 32'h200 + 32'(4 * k));
    end
    d_jump_req    = 1'b1;
    d_jump_target = 32'h300;
    @(negedge clock);
    d_jump_target = 32'h400;
    @(negedge clock);
    d_jump_req = 1'b0;
    chk("b2b_flush", 32'(count), 32'd0);
    @(negedge clock);
    chk("b2b_addr", d_address, 32'h400);

    // wrap-around with toggling ready
    do_reset();
    consumed = 0;
    exp_addr = 32'h0;
    cyc      = 0;
    while (consumed < 10 && cyc < 80) begin
      chk("wrap_cnt_le4", 32'(count <= 3'd4), 32'd1);
      if (d_valid) begin
        chk("wrap_addr", d_address, exp_addr);
        chk("wrap_instr", d_instruction, instr_of(exp_addr));
      end
      d_ready = cyc[0] ? 1'b0 : 1'b1;
      if (d_valid && d_ready) begin
        consumed++;
        exp_addr = exp_addr + 32'd4;
      end
      @(negedge clock);
      cyc++;
    end
    chk("wrap_done", 32'(consumed), 32'd10);

    // asynchronous reset mid-stream
    do_reset();
    d_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("ar_count_pre", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(d_valid), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    d_ready = 1'b1;
    @(negedge clock);
    chk("ar_resume_v", 32'(d_valid), 32'd1);
    chk("ar_resume_a", d_address, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction buffer on the consumer side of the fetch stage; it sits between fetch and decode. It captures each instruction/address pair fetch presents and buffers it in a small FIFO, which decode drains with a valid/ready handshake. It drives the fetch-side stall when full, and forwards decode's jump redirect to fetch. On a redirect it flushes all buffered wrong-path instructions.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
PTR_W, 2, log2(DEPTH); pointer width
WORD_W, 32, instruction and address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
f_instruction  in  WORD_W  instruction currently presented by fetch; valid every cycle
f_address  in  WORD_W  address of f_instruction
f_stall  out  1  to fetch stall input; 1 = hold PC
f_jump_target  out  WORD_W  to fetch jump_target
f_jump_flg  out  1  to fetch jump_flg
d_jump_req  in  1  decode requests a redirect this cycle
d_jump_target  in  WORD_W  redirect address
d_valid  out  1  head entry is valid
d_instruction  out  WORD_W  head entry instruction
d_address  out  WORD_W  head entry address
d_ready  in  1  decode accepts the head entry this cycle
count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-operation):
  - rd_ptr = wr_ptr = 0 and count = 0.
  - d_valid = 0 and f_stall = 0.
  - Storage array is not reset.
  - d_instruction/d_address are don't-care while d_valid = 0.
- Redirect pass-through (combinational): f_jump_flg = d_jump_req; f_jump_target = d_jump_target.
- Stall: f_stall = (count == DEPTH) && !d_jump_req. It depends only on registered count plus d_jump_req, with no path from d_ready.
- Enqueue: enq = !f_stall && !d_jump_req.
  - On the rising edge, write {f_instruction, f_address} to mem[wr_ptr] and advance wr_ptr.
  - Pointers wrap modulo DEPTH.
- Dequeue: deq = d_valid && d_ready.
  - On the rising edge, rd_ptr advances, modulo DEPTH.
  - d_valid = (count != 0).
  - d_instruction and d_address = mem[rd_ptr], a combinational read of registered storage.
- Count update:
  - enq && !deq: count + 1.
  - deq && !enq: count − 1.
  - Both or neither: unchanged.
- Latency: an entry enqueued at edge N is visible on d_* after edge N, one cycle fetch-to-decode minimum.
- Full (count == DEPTH):
  - f_stall is high and no enqueue happens. Fetch holds its PC, so the same instruction is re-presented and nothing is lost.
  - A dequeue while full frees a slot; f_stall drops the next cycle.
  - Consequence: one bubble per full→drain transition. This is accepted; there is no same-cycle enq-on-deq while full.
- Empty (count == 0): d_valid = 0; d_ready is ignored.
- Redirect cycle (d_jump_req = 1):
  - f_stall is forced 0 so fetch loads the target.
  - No enqueue: the presented instruction is wrong-path.
  - A concurrent handshake (deq) still counts as consumed, since decode is issuing the jump from the head instruction.
  - At the edge, flush: rd_ptr = wr_ptr = 0, count = 0, overriding any enq/deq update.
  - The next cycle fetch presents the target instruction and it is enqueued normally. Fetch to d_valid after a redirect takes 2 cycles.
- Back-to-back d_jump_req: each cycle flushes; the last target wins.
- Invariant: count == (wr_ptr − rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and the queue is full.

Decomposition:
- Shared package: WORD_W = 32, FQ_DEPTH_DEFAULT = 4, and the derived pointer-width function.
- One natural sub-module: fetch_queue_mem.
  - DEPTH×(2·WORD_W) register array.
  - Synchronous write port, asynchronous read port.
  - No reset.
- Pointer, count, stall and flush logic stay in fetch_queue.

Test Plan:
- Reset then free-run: fetch model presents addr 0x00,0x04,0x08…, with d_ready = 1. Expected: d_valid rises 1 cycle after the first enqueue edge; d_address sequence is 0x00,0x04,0x08 with no gaps; f_stall stays 0.
- Fill: d_ready = 0 for 6 cycles. Expected: count goes 1,2,3,4; f_stall = 1 once count = 4; fetch PC holds at 0x10; entries are 0x00..0x0C. Then raise d_ready: drains 0x00 first, f_stall drops the next cycle, then 0x10 is enqueued exactly once.
- Redirect: with count = 3, assert d_jump_req with d_jump_target = 0x100 for one cycle. Expected: f_jump_flg = 1 and f_jump_target = 0x100 the same cycle; count = 0 after the edge; 2 cycles later d_address = 0x100.
- Redirect while full: with count = 4 and f_stall = 1, assert d_jump_req. Expected: f_stall = 0 that cycle; queue flushed; no stale entry (0x00..0x0C) ever appears on d_* afterwards.
- Wrap-around: stream 10 instructions with d_ready toggling 1,0,1,0…. Expected: the d_address order exactly matches the fetch order across pointer wraps; count never exceeds 4.
- Async reset mid-stream: assert reset between edges with count = 2. Expected: d_valid = 0 and count = 0 immediately, without waiting for a clock edge; after release, the queue resumes from fetch's reset address.
